// File: rtl/fp_csr_multilane.sv
// RV32F floating-point CSR block: gathers lane exception flags through a flushable
// pending stage, runs CSRRW/CSRRS/CSRRC on fflags/frm/fcsr, tracks mstatus.FS, resolves rm.
module fp_csr_multilane #(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned FLAG_W    = 5
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          csr_valid,
    input  logic [1:0]                    csr_op,
    input  logic [11:0]                   csr_addr,
    input  logic [31:0]                   csr_wdata,
    output logic [31:0]                   csr_rdata,
    output logic                          csr_hit,
    output logic                          csr_illegal,
    input  logic [NUM_LANES-1:0]          fp_valid,
    input  logic [FLAG_W*NUM_LANES-1:0]   fp_flags,
    input  logic                          flush,
    input  logic [2:0]                    inst_rm,
    output logic [2:0]                    rm_out,
    output logic                          rm_illegal,
    input  logic                          fs_write,
    input  logic [1:0]                    fs_wdata,
    output logic [1:0]                    fs,
    output logic [FLAG_W-1:0]             fflags,
    output logic [2:0]                    frm,
    output logic                          flags_pend
);

    localparam int unsigned RDATA_PAD = 32 - 3 - FLAG_W;

    localparam logic [1:0] FS_OFF   = 2'b00;
    localparam logic [1:0] FS_INIT  = 2'b01;
    localparam logic [1:0] FS_DIRTY = 2'b11;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;

    localparam logic [11:0] ADDR_FFLAGS = 12'h001;
    localparam logic [11:0] ADDR_FRM    = 12'h002;
    localparam logic [11:0] ADDR_FCSR   = 12'h003;

    logic [FLAG_W-1:0] fflags_q, fflags_d;
    logic [2:0]        frm_q, frm_d;
    logic              pend_valid_q, pend_valid_d;
    logic [FLAG_W-1:0] pend_flags_q, pend_flags_d;
    logic [1:0]        fs_q, fs_d;

    logic              fs_off;
    logic              pend_live;
    logic [FLAG_W-1:0] fflags_view;
    logic [FLAG_W-1:0] lane_or;
    logic              csr_wr;
    logic [31:0]       wval;

    // OR together the flag slices of all lanes reporting this cycle
    always_comb begin
        lane_or = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (fp_valid[i]) lane_or = lane_or | fp_flags[i*FLAG_W +: FLAG_W];
        end
    end

    assign fs_off      = (fs_q == FS_OFF);
    assign pend_live   = pend_valid_q & ~flush;
    assign fflags_view = fflags_q | (pend_live ? pend_flags_q : '0);

    assign csr_hit     = csr_valid & ((csr_addr == ADDR_FFLAGS) | (csr_addr == ADDR_FRM) |
                                      (csr_addr == ADDR_FCSR));
    assign csr_illegal = csr_hit & fs_off;
    assign csr_wr      = csr_hit & ~fs_off & (csr_op != OP_READ);

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            ADDR_FFLAGS: csr_rdata = {(32 - FLAG_W)'(0), fflags_view};
            ADDR_FRM:    csr_rdata = {29'd0, frm_q};
            ADDR_FCSR:   csr_rdata = {RDATA_PAD'(0), frm_q, fflags_view};
            default:     csr_rdata = '0;
        endcase
    end

    // Read-modify-write value; old already includes any surviving pending flags
    always_comb begin
        case (csr_op)
            OP_RW:   wval = csr_wdata;
            OP_RS:   wval = csr_rdata | csr_wdata;
            default: wval = csr_rdata & ~csr_wdata;
        endcase
    end

    always_comb begin
        fflags_d     = fflags_view;
        frm_d        = frm_q;
        pend_valid_d = (|fp_valid) & ~flush & ~fs_off;
        pend_flags_d = pend_valid_d ? lane_or : '0;
        if (csr_wr) begin
            case (csr_addr)
                ADDR_FFLAGS: fflags_d = wval[FLAG_W-1:0];
                ADDR_FRM:    frm_d    = wval[2:0];
                default: begin
                    fflags_d = wval[FLAG_W-1:0];
                    frm_d    = wval[FLAG_W+2:FLAG_W];
                end
            endcase
        end
    end

    // FS next-state: mstatus write first, then dirtying by flag commit or CSR write
    always_comb begin
        fs_d = fs_q;
        if (fs_write) begin
            fs_d = fs_wdata;
        end else if (!fs_off && (pend_live ||
                   (csr_wr && ((csr_op == OP_RW) || (fflags_d != fflags_q) ||
                               (frm_d != frm_q))))) begin
            fs_d = FS_DIRTY;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fs_q <= FS_INIT;
        end else begin
            fs_q <= fs_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fflags_q     <= '0;
            frm_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_flags_q <= '0;
        end else begin
            fflags_q     <= fflags_d;
            frm_q        <= frm_d;
            pend_valid_q <= pend_valid_d;
            pend_flags_q <= pend_flags_d;
        end
    end

    assign rm_out     = (inst_rm == 3'b111) ? frm_q : inst_rm;
    assign rm_illegal = (rm_out == 3'b101) | (rm_out == 3'b110) | (rm_out == 3'b111) | fs_off;

    assign fs         = fs_q;
    assign fflags     = fflags_q;
    assign frm        = frm_q;
    assign flags_pend = pend_valid_q;

endmodule
